// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: operation and state
// encodings, default width and the architectural special-case constants.
package ex_div_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Architectural results for the two special cases.
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // DIV and REM interpret operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit
// (MSB of the quotient register) into the partial remainder, subtract the
// divisor when it fits and record the outcome as the new quotient LSB.
module div_restoring_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] q_o
);

  // The shifted remainder is kept one bit wider than XLEN: with an unsigned
  // divisor above 2^(XLEN-1) the partial remainder can have its MSB set, and
  // dropping it before the compare would give wrong quotients.
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] diff;

  // Trial subtraction and restore decision.
  always_comb begin
    rem_shift = {rem_i, q_i[XLEN-1]};
    diff      = rem_shift[XLEN-1:0] - divisor_i;
    if (rem_shift >= {1'b0, divisor_i}) begin
      rem_o = diff;
      q_o   = {q_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_shift[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// EX-stage iterative divider for DIV/DIVU/REM/REMU.
// Signed operands are converted to magnitudes at start, XLEN restoring
// iterations run in CALC, and the sign fix plus special-case override is
// applied while registering RESULT on the way into DONE.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero, signed overflow and
// divisor==1 skip CALC and reach DONE on the cycle after START.
//
// Handshake: STALL is combinational and high from the cycle START is accepted
// in IDLE until the last CALC cycle; DONE is a registered one-cycle pulse with
// RESULT valid in that same cycle, when STALL is low so the instruction leaves EX.
// DBG_STATE_O exposes the FSM state for observation.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      DIV_OP,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [1:0]      DBG_STATE_O
);

  localparam logic [XLEN-1:0] Q_ALL_ONES = DIV_BY_ZERO_Q[XLEN-1:0];
  localparam logic [XLEN-1:0] SMIN       = SIGNED_MIN[31:32-XLEN];
  localparam logic [CNT_W-1:0] CNT_LOAD  = XLEN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_LAST  = {{(CNT_W-1){1'b0}}, 1'b1};

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] dvs_q;
  logic            is_rem_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            div0_q;
  logic            ovf_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            op_signed;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div0_in;
  logic            ovf_in;
  logic            q_neg_in;
  logic            r_neg_in;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_q;

  // Final mux: special cases override, otherwise restore the signs.
  // Divide-by-zero remainder needs no override: the iteration leaves the
  // dividend magnitude in the remainder and the sign fix restores it.
  function automatic logic [XLEN-1:0] fix_result(
    input logic            is_rem,
    input logic            q_neg,
    input logic            r_neg,
    input logic            div0,
    input logic            ovf,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] res;
    if (is_rem) begin
      if (ovf) res = '0;
      else     res = r_neg ? -r : r;
    end else begin
      if (div0)     res = Q_ALL_ONES;
      else if (ovf) res = SMIN;
      else          res = q_neg ? -q : q;
    end
    return res;
  endfunction

  // Operand conditioning for the start cycle; sign flags already include signedness.
  always_comb begin
    op_signed = op_is_signed(DIV_OP);
    abs1      = (op_signed & OPERAND1[XLEN-1]) ? -OPERAND1 : OPERAND1;
    abs2      = (op_signed & OPERAND2[XLEN-1]) ? -OPERAND2 : OPERAND2;
    div0_in   = (OPERAND2 == '0);
    ovf_in    = op_signed & (OPERAND1 == SMIN) & (OPERAND2 == '1);
    q_neg_in  = op_signed & (OPERAND1[XLEN-1] ^ OPERAND2[XLEN-1]);
    r_neg_in  = op_signed & OPERAND1[XLEN-1];
  end

`ifdef DIV_FAST_PATH_EN
  logic fast_in;
  // Cases whose result is known without iterating.
  always_comb begin
    fast_in = div0_in | ovf_in | (OPERAND2 == {{(XLEN-1){1'b0}}, 1'b1});
  end
`endif

  div_restoring_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // Divider FSM with registered DONE/RESULT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START && !FLUSH) begin
            rem_q    <= '0;
            q_q      <= abs1;
            dvs_q    <= abs2;
            is_rem_q <= op_is_rem(DIV_OP);
            q_neg_q  <= q_neg_in;
            r_neg_q  <= r_neg_in;
            div0_q   <= div0_in;
            ovf_q    <= ovf_in;
            cnt_q    <= CNT_LOAD;
            state_q  <= ST_CALC;
`ifdef DIV_FAST_PATH_EN
            if (fast_in) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= fix_result(op_is_rem(DIV_OP), q_neg_in, r_neg_in,
                                     div0_in, ovf_in, abs1,
                                     div0_in ? abs1 : '0);
            end
`endif
          end
        end
        ST_CALC: begin
          if (FLUSH) begin
            state_q <= ST_IDLE;
          end else begin
            rem_q <= step_rem;
            q_q   <= step_q;
            cnt_q <= cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= fix_result(is_rem_q, q_neg_q, r_neg_q, div0_q,
                                     ovf_q, step_q, step_rem);
            end
          end
        end
        ST_DONE: begin
          // START still high here belongs to the finishing instruction.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign STALL       = ((state_q == ST_IDLE) & START & ~FLUSH) | (state_q == ST_CALC);
  assign DONE        = done_q;
  assign RESULT      = result_q;
  assign DBG_STATE_O = state_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed divides, special cases,
// flush, mid-operation reset, back-to-back and random operations.
module tb_ex_div_unit;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [1:0]  DIV_OP;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic        FLUSH;
  logic        STALL;
  logic        DONE;
  logic [31:0] RESULT;
  logic [1:0]  DBG_STATE_O;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  ex_div_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .DIV_OP      (DIV_OP),
    .OPERAND1    (OPERAND1),
    .OPERAND2    (OPERAND2),
    .FLUSH       (FLUSH),
    .STALL       (STALL),
    .DONE        (DONE),
    .RESULT      (RESULT),
    .DBG_STATE_O (DBG_STATE_O)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference results following the RISC-V M-extension definitions.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00: if (b == 0) r = 32'hFFFF_FFFF; else if (ovf) r = 32'h8000_0000; else r = $signed(a) / $signed(b);
      2'b01: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      2'b10: if (b == 0) r = a; else if (ovf) r = 32'h0; else r = $signed(a) % $signed(b);
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  // Cycle index of DONE relative to the START cycle (also the STALL length).
  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef DIV_FAST_PATH_EN
    if ((b == 0) || (b == 1) ||
        (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) lat = 1;
`else
    if (op == 2'b11 && a == 32'h0 && b == 32'h0) lat = 33;
`endif
    return lat;
  endfunction

  // Driver: issue one divide, hold START until DONE, score the result and timing.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int t;
    int stall_cnt;
    int lat;
    logic got;
    logic [31:0] exp;
    lat = exp_latency(op, a, b);
    @(negedge CLK);
    START = 1'b1; DIV_OP = op; OPERAND1 = a; OPERAND2 = b;
    exp_q.push_back(model(op, a, b));
    t = 0; stall_cnt = 0; got = 1'b0;
    while (t < 100) begin
      #1;
      if (DONE) begin
        got = 1'b1;
        break;
      end
      if (STALL) stall_cnt++;
      @(negedge CLK);
      t++;
    end
    START = 1'b0;
    exp = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: no DONE within %0d cycles, required DONE", name, t);
      RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
    end else begin
      if (RESULT !== exp) begin
        bad++;
        $display("FAIL %s result: got %h required %h", name, RESULT, exp);
      end
      total++;
      if (t !== lat) begin
        bad++;
        $display("FAIL %s done_cycle: got T%0d required T%0d", name, t, lat);
      end
      total++;
      if (stall_cnt !== lat) begin
        bad++;
        $display("FAIL %s stall_cycles: got %0d required %0d", name, stall_cnt, lat);
      end
      last_exp = exp;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; DIV_OP = 2'b00; OPERAND1 = 32'h0; OPERAND2 = 32'h0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    total++;
    if (DONE !== 1'b0 || STALL !== 1'b0 || RESULT !== 32'h0 || DBG_STATE_O !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: got done=%b stall=%b result=%h state=%0d required 0 0 0 0",
               DONE, STALL, RESULT, DBG_STATE_O);
    end
  endtask

  task automatic test_unsigned;
    do_div(2'b01, 32'd100, 32'd7, "divu_100_7");
    do_div(2'b11, 32'd100, 32'd7, "remu_100_7");
    do_div(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, "divu_large");
    do_div(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, "remu_large");
  endtask

  task automatic test_signed;
    do_div(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    do_div(2'b00, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    do_div(2'b00, 32'hFFFF_FFF9, 32'd1, "div_m7_1");
  endtask

  task automatic test_special;
    do_div(2'b00, 32'h1234_5678, 32'h0, "div_by_zero");
    do_div(2'b10, 32'h1234_5678, 32'h0, "rem_by_zero");
    do_div(2'b10, 32'hF234_5678, 32'h0, "rem_neg_by_zero");
    do_div(2'b01, 32'hF234_5678, 32'h0, "divu_by_zero");
    do_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
  endtask

  task automatic test_flush;
    logic saw_done;
    // START with FLUSH in IDLE must not start anything.
    @(negedge CLK);
    START = 1'b1; FLUSH = 1'b1; DIV_OP = 2'b01; OPERAND1 = 32'd50; OPERAND2 = 32'd5;
    #1;
    total++;
    if (STALL !== 1'b0) begin bad++; $display("FAIL flush_idle_stall: got %b required 0", STALL); end
    @(negedge CLK);
    START = 1'b0; FLUSH = 1'b0;
    #1;
    total++;
    if (DBG_STATE_O !== 2'b00) begin bad++; $display("FAIL flush_idle_state: got %0d required 0", DBG_STATE_O); end
    // Flush at T10 of a running divide.
    @(negedge CLK);
    START = 1'b1; DIV_OP = 2'b01; OPERAND1 = 32'd50; OPERAND2 = 32'd5;
    repeat (10) @(negedge CLK);
    FLUSH = 1'b1;
    #1;
    total++;
    if (STALL !== 1'b1) begin bad++; $display("FAIL flush_t10_stall: got %b required 1", STALL); end
    @(negedge CLK);
    FLUSH = 1'b0; START = 1'b0;
    #1;
    total++;
    if (STALL !== 1'b0 || DBG_STATE_O !== 2'b00) begin
      bad++;
      $display("FAIL flush_t11: got stall=%b state=%0d required 0 0", STALL, DBG_STATE_O);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK); #1;
      if (DONE) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL flush_no_done: got DONE=1 required 0"); end
    total++;
    if (RESULT !== last_exp) begin bad++; $display("FAIL flush_result_hold: got %h required %h", RESULT, last_exp); end
    do_div(2'b01, 32'd50, 32'd5, "divu_after_flush");
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    START = 1'b1; DIV_OP = 2'b01; OPERAND1 = 32'd100; OPERAND2 = 32'd7;
    repeat (5) @(negedge CLK);
    RESET = 1'b1; START = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    total++;
    if (STALL !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'h0 || DBG_STATE_O !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid: got stall=%b done=%b result=%h state=%0d required 0 0 0 0",
               STALL, DONE, RESULT, DBG_STATE_O);
    end
  endtask

  task automatic test_back_to_back;
    do_div(2'b01, 32'd9, 32'd3, "b2b_divu_9_3");
    do_div(2'b11, 32'd9, 32'd4, "b2b_remu_9_4");
    do_div(2'b00, 32'd9, 32'd0, "b2b_div_9_0");
    do_div(2'b10, 32'hFFFF_FFF7, 32'd4, "b2b_rem_m9_4");
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 2));
        1:       b = 32'($urandom_range(3, 20));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: b = $urandom();
      endcase
      do_div(op, a, b, "random");
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
